// File: rtl/digit_entry_buffer_if.sv
// Command and operand bus of the calculator digit-entry buffer.
// The keypad/ALU controller is the master and the buffer is the slave.
interface digit_entry_buffer_if #(
  parameter int NUM_DIGITS = 10,
  parameter int DIGIT_W    = 4
);
  localparam int CNT_W  = $clog2(NUM_DIGITS + 1);
  localparam int DATA_W = NUM_DIGITS * DIGIT_W;

  logic               digit_vld;
  logic [DIGIT_W-1:0] digit_in;
  logic               bksp;
  logic               clr;
  logic               neg;
  logic               load;
  logic [DATA_W-1:0]  load_data;
  logic               load_sign;
  logic [DATA_W-1:0]  digits;
  logic [CNT_W-1:0]   count;
  logic               sign;
  logic               empty;
  logic               full;
  logic               is_result;
  logic               reject;

  modport master (
    output digit_vld, digit_in, bksp, clr, neg, load, load_data, load_sign,
    input  digits, count, sign, empty, full, is_result, reject
  );

  modport slave (
    input  digit_vld, digit_in, bksp, clr, neg, load, load_data, load_sign,
    output digits, count, sign, empty, full, is_result, reject
  );
endinterface

// File: rtl/digit_entry_buffer.sv
// Operand-entry buffer: keypad digits shift in at slot 0, with backspace, clear,
// sign toggle and result preload. A result is replaced by the next digit typed.
module digit_entry_buffer #(
  parameter int NUM_DIGITS = 10,
  parameter int DIGIT_W    = 4,
  parameter int RADIX      = 16
) (
  input logic                 clock,
  input logic                 reset,
  digit_entry_buffer_if.slave bus
);
  localparam int CNT_W  = $clog2(NUM_DIGITS + 1);
  localparam int DATA_W = NUM_DIGITS * DIGIT_W;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(NUM_DIGITS);

  typedef enum logic [1:0] {
    ST_EMPTY  = 2'd0,
    ST_ENTRY  = 2'd1,
    ST_RESULT = 2'd2
  } state_t;

  state_t             state_r;
  logic [DATA_W-1:0]  digits_r;
  logic [CNT_W-1:0]   count_r;
  logic               sign_r;
  logic               reject_r;

  logic               digit_ok_s;
  logic               digit_zero_s;
  logic               full_s;
  logic [DATA_W-1:0]  shift_up_s;
  logic [DATA_W-1:0]  shift_down_s;
  logic [DATA_W-1:0]  fresh_digit_s;
  logic [CNT_W-1:0]   load_cnt_s;

  // Number of significant digits in a preloaded result: highest nonzero slot + 1.
  function automatic logic [CNT_W-1:0] msd_count(input logic [DATA_W-1:0] d);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (d[i*DIGIT_W +: DIGIT_W] != '0) begin
        c = CNT_W'(i + 1);
      end else begin
        c = c;
      end
    end
    return c;
  endfunction

  // Candidate operand values and decode of the incoming digit.
  always_comb begin
    digit_ok_s    = (int'(bus.digit_in) < RADIX);
    digit_zero_s  = (bus.digit_in == '0);
    full_s        = (count_r == FULL_CNT);
    shift_up_s    = {digits_r[DATA_W-DIGIT_W-1:0], bus.digit_in};
    shift_down_s  = {{DIGIT_W{1'b0}}, digits_r[DATA_W-1:DIGIT_W]};
    fresh_digit_s = {{(DATA_W-DIGIT_W){1'b0}}, bus.digit_in};
    load_cnt_s    = msd_count(bus.load_data);
  end

  // Entry state machine; priority clr > load > bksp > digit_vld > neg.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r  <= ST_EMPTY;
      digits_r <= '0;
      count_r  <= '0;
      sign_r   <= 1'b0;
      reject_r <= 1'b0;
    end else begin
      reject_r <= 1'b0;
      if (bus.clr) begin
        state_r  <= ST_EMPTY;
        digits_r <= '0;
        count_r  <= '0;
        sign_r   <= 1'b0;
      end else if (bus.load) begin
        state_r  <= ST_RESULT;
        digits_r <= bus.load_data;
        count_r  <= load_cnt_s;
        sign_r   <= bus.load_sign;
      end else if (bus.bksp) begin
        case (state_r)
          ST_EMPTY: begin
            reject_r <= 1'b1;
          end
          ST_ENTRY: begin
            digits_r <= shift_down_s;
            count_r  <= count_r - CNT_W'(1);
            if (count_r == CNT_W'(1)) begin
              state_r <= ST_EMPTY;
              sign_r  <= 1'b0;
            end else begin
              state_r <= ST_ENTRY;
            end
          end
          ST_RESULT: begin
            state_r  <= ST_EMPTY;
            digits_r <= '0;
            count_r  <= '0;
            sign_r   <= 1'b0;
          end
          default: begin
            state_r  <= ST_EMPTY;
            digits_r <= '0;
            count_r  <= '0;
            sign_r   <= 1'b0;
          end
        endcase
      end else if (bus.digit_vld) begin
        if (!digit_ok_s) begin
          reject_r <= 1'b1;
        end else begin
          case (state_r)
            ST_RESULT: begin
              // Result is discarded; the digit then enters an empty buffer.
              sign_r <= 1'b0;
              if (digit_zero_s) begin
                state_r  <= ST_EMPTY;
                digits_r <= '0;
                count_r  <= '0;
              end else begin
                state_r  <= ST_ENTRY;
                digits_r <= fresh_digit_s;
                count_r  <= CNT_W'(1);
              end
            end
            ST_EMPTY: begin
              if (digit_zero_s) begin
                state_r <= ST_EMPTY;
              end else begin
                state_r  <= ST_ENTRY;
                digits_r <= fresh_digit_s;
                count_r  <= CNT_W'(1);
              end
            end
            ST_ENTRY: begin
              if (full_s) begin
                reject_r <= 1'b1;
              end else begin
                digits_r <= shift_up_s;
                count_r  <= count_r + CNT_W'(1);
              end
            end
            default: begin
              state_r  <= ST_EMPTY;
              digits_r <= '0;
              count_r  <= '0;
              sign_r   <= 1'b0;
            end
          endcase
        end
      end else if (bus.neg) begin
        if (state_r != ST_EMPTY) begin
          sign_r <= ~sign_r;
        end else begin
          sign_r <= 1'b0;
        end
      end else begin
        state_r <= state_r;
      end
    end
  end

  assign bus.digits    = digits_r;
  assign bus.count     = count_r;
  assign bus.sign      = sign_r;
  assign bus.reject    = reject_r;
  assign bus.empty     = (count_r == '0);
  assign bus.full      = (count_r == FULL_CNT);
  assign bus.is_result = (state_r == ST_RESULT);
endmodule

// File: tb/tb_digit_entry_buffer.sv
// Directed bench for digit_entry_buffer: a vector table plus hand-written
// sequences for fill/reject, radix limit and asynchronous reset.
module tb_digit_entry_buffer;
  logic clock;
  logic reset;

  digit_entry_buffer_if #(.NUM_DIGITS(10), .DIGIT_W(4)) bus16 ();
  digit_entry_buffer_if #(.NUM_DIGITS(10), .DIGIT_W(4)) bus10 ();

  digit_entry_buffer #(.NUM_DIGITS(10), .DIGIT_W(4), .RADIX(16)) dut16 (
    .clock (clock),
    .reset (reset),
    .bus   (bus16.slave)
  );

  digit_entry_buffer #(.NUM_DIGITS(10), .DIGIT_W(4), .RADIX(10)) dut10 (
    .clock (clock),
    .reset (reset),
    .bus   (bus10.slave)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct {
    logic        clr, load, bksp, vld, neg;
    logic [3:0]  din;
    logic [39:0] ldata;
    logic        lsign;
    logic [39:0] e_digits;
    logic [3:0]  e_count;
    logic        e_sign, e_res, e_rej;
  } vec_t;

  int checks;
  int failures;
  vec_t vecs[28];

  function automatic vec_t mk(input logic c, l, b, d, n, input logic [3:0] din,
                              input logic [39:0] ld, input logic ls,
                              input logic [39:0] ed, input logic [3:0] ec,
                              input logic es, er, ej);
    vec_t v;
    v.clr = c; v.load = l; v.bksp = b; v.vld = d; v.neg = n;
    v.din = din; v.ldata = ld; v.lsign = ls;
    v.e_digits = ed; v.e_count = ec; v.e_sign = es; v.e_res = er; v.e_rej = ej;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic chk16(input string tag, input logic [39:0] ed, input logic [3:0] ec,
                       input logic es, input logic er, input logic ej);
    chk({tag, ".digits"},    64'(bus16.digits),    64'(ed));
    chk({tag, ".count"},     64'(bus16.count),     64'(ec));
    chk({tag, ".sign"},      64'(bus16.sign),      64'(es));
    chk({tag, ".empty"},     64'(bus16.empty),     64'(ec == 4'd0));
    chk({tag, ".full"},      64'(bus16.full),      64'(ec == 4'd10));
    chk({tag, ".is_result"}, 64'(bus16.is_result), 64'(er));
    chk({tag, ".reject"},    64'(bus16.reject),    64'(ej));
  endtask

  // Called at a negedge: hold the command for one cycle, return at the next negedge.
  task automatic drive16(input vec_t v);
    bus16.clr = v.clr; bus16.load = v.load; bus16.bksp = v.bksp;
    bus16.digit_vld = v.vld; bus16.neg = v.neg; bus16.digit_in = v.din;
    bus16.load_data = v.ldata; bus16.load_sign = v.lsign;
    @(negedge clock);
    bus16.clr = 1'b0; bus16.load = 1'b0; bus16.bksp = 1'b0;
    bus16.digit_vld = 1'b0; bus16.neg = 1'b0; bus16.digit_in = 4'd0;
    bus16.load_data = 40'd0; bus16.load_sign = 1'b0;
  endtask

  task automatic push16(input logic [3:0] d);
    drive16(mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, d, 40'd0, 1'b0,
               40'd0, 4'd0, 1'b0, 1'b0, 1'b0));
  endtask

  task automatic push10(input logic [3:0] d);
    bus10.digit_vld = 1'b1;
    bus10.digit_in  = d;
    @(negedge clock);
    bus10.digit_vld = 1'b0;
    bus10.digit_in  = 4'd0;
  endtask

  initial begin
    logic [39:0] fill_exp;
    checks   = 0;
    failures = 0;
    reset    = 1'b0;
    bus16.clr = 1'b0; bus16.load = 1'b0; bus16.bksp = 1'b0; bus16.digit_vld = 1'b0;
    bus16.neg = 1'b0; bus16.digit_in = 4'd0; bus16.load_data = 40'd0; bus16.load_sign = 1'b0;
    bus10.clr = 1'b0; bus10.load = 1'b0; bus10.bksp = 1'b0; bus10.digit_vld = 1'b0;
    bus10.neg = 1'b0; bus10.digit_in = 4'd0; bus10.load_data = 40'd0; bus10.load_sign = 1'b0;

    //            clr   load  bksp  vld   neg   din   load_data           ls    digits              cnt   sgn   res   rej
    vecs[0]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 40'h0,              1'b0, 40'h0,              4'd0, 1'b0, 1'b0, 1'b0);
    vecs[1]  = mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h1, 40'h0,              1'b0, 40'h1,              4'd1, 1'b0, 1'b0, 1'b0);
    vecs[2]  = mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h2, 40'h0,              1'b0, 40'h12,             4'd2, 1'b0, 1'b0, 1'b0);
    vecs[3]  = mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h3, 40'h0,              1'b0, 40'h123,            4'd3, 1'b0, 1'b0, 1'b0);
    vecs[4]  = mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 40'h0,              1'b0, 40'h12,             4'd2, 1'b0, 1'b0, 1'b0);
    vecs[5]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 40'h0,              1'b0, 40'h12,             4'd2, 1'b1, 1'b0, 1'b0);
    vecs[6]  = mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 40'h0,              1'b0, 40'h1,              4'd1, 1'b1, 1'b0, 1'b0);
    vecs[7]  = mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 40'h0,              1'b0, 40'h0,              4'd0, 1'b0, 1'b0, 1'b0);
    vecs[8]  = mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 40'h0,              1'b0, 40'h0,              4'd0, 1'b0, 1'b0, 1'b1);
    vecs[9]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 40'h0,              1'b0, 40'h0,              4'd0, 1'b0, 1'b0, 1'b0);
    vecs[10] = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 40'h0,              1'b0, 40'h0,              4'd0, 1'b0, 1'b0, 1'b0);
    vecs[11] = mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 40'h0,              1'b0, 40'h0,              4'd0, 1'b0, 1'b0, 1'b0);
    vecs[12] = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 40'h0000000F00,     1'b1, 40'h0000000F00,     4'd3, 1'b1, 1'b1, 1'b0);
    vecs[13] = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 40'h0,              1'b0, 40'h0000000F00,     4'd3, 1'b0, 1'b1, 1'b0);
    vecs[14] = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 40'h0,              1'b0, 40'h0000000F00,     4'd3, 1'b1, 1'b1, 1'b0);
    vecs[15] = mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h5, 40'h0,              1'b0, 40'h5,              4'd1, 1'b0, 1'b0, 1'b0);
    vecs[16] = mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 40'h0,              1'b0, 40'h50,             4'd2, 1'b0, 1'b0, 1'b0);
    vecs[17] = mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'h9, 40'h0,              1'b0, 40'h0,              4'd0, 1'b0, 1'b0, 1'b0);
    vecs[18] = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 40'h0,              1'b0, 40'h0,              4'd0, 1'b0, 1'b1, 1'b0);
    vecs[19] = mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 40'h0,              1'b0, 40'h0,              4'd0, 1'b0, 1'b0, 1'b0);
    vecs[20] = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 40'h0000000123,     1'b1, 40'h0000000123,     4'd3, 1'b1, 1'b1, 1'b0);
    vecs[21] = mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 40'h0,              1'b0, 40'h0,              4'd0, 1'b0, 1'b0, 1'b0);
    vecs[22] = mk(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'h3, 40'h8000000000,     1'b0, 40'h8000000000,     4'd10, 1'b0, 1'b1, 1'b0);
    vecs[23] = mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h7, 40'h0,              1'b0, 40'h7,              4'd1, 1'b0, 1'b0, 1'b0);
    vecs[24] = mk(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'h4, 40'h0,              1'b0, 40'h0,              4'd0, 1'b0, 1'b0, 1'b0);
    vecs[25] = mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'hF, 40'h0,              1'b0, 40'hF,              4'd1, 1'b0, 1'b0, 1'b0);
    vecs[26] = mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h1, 40'h0,              1'b0, 40'hF1,             4'd2, 1'b0, 1'b0, 1'b0);
    vecs[27] = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 40'h0,              1'b0, 40'h0,              4'd0, 1'b0, 1'b0, 1'b0);

    repeat (2) @(negedge clock);
    chk16("reset", 40'h0, 4'd0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    @(negedge clock);

    for (int i = 0; i < 28; i++) begin
      drive16(vecs[i]);
      chk16($sformatf("vec%0d", i), vecs[i].e_digits, vecs[i].e_count,
            vecs[i].e_sign, vecs[i].e_res, vecs[i].e_rej);
    end

    // Fill all ten slots, then overflow.
    for (int i = 1; i <= 10; i++) begin
      push16(4'(i));
    end
    fill_exp = 40'h123456789A;
    chk16("fill", fill_exp, 4'd10, 1'b0, 1'b0, 1'b0);
    push16(4'h7);
    chk16("overflow", fill_exp, 4'd10, 1'b0, 1'b0, 1'b1);
    drive16(vecs[0]);
    chk16("overflow_idle", fill_exp, 4'd10, 1'b0, 1'b0, 1'b0);
    drive16(vecs[4]);
    chk16("unfill_bksp", 40'h0123456789, 4'd9, 1'b0, 1'b0, 1'b0);
    drive16(vecs[27]);

    // Radix-10 instance: non-decimal digits rejected, leading zero ignored.
    push10(4'hA);
    chk("r10_a.reject", 64'(bus10.reject), 64'd1);
    chk("r10_a.count",  64'(bus10.count),  64'd0);
    push10(4'h0);
    chk("r10_0.count",  64'(bus10.count),  64'd0);
    chk("r10_0.reject", 64'(bus10.reject), 64'd0);
    chk("r10_0.empty",  64'(bus10.empty),  64'd1);
    push10(4'h9);
    chk("r10_9.digits", 64'(bus10.digits), 64'h9);
    chk("r10_9.count",  64'(bus10.count),  64'd1);
    push10(4'hB);
    chk("r10_b.reject", 64'(bus10.reject), 64'd1);
    chk("r10_b.digits", 64'(bus10.digits), 64'h9);

    // Asynchronous reset in the middle of an entry.
    push16(4'h1);
    push16(4'h2);
    push16(4'h3);
    chk16("pre_reset", 40'h123, 4'd3, 1'b0, 1'b0, 1'b0);
    #2 reset = 1'b0;
    #1;
    chk16("async_reset", 40'h0, 4'd0, 1'b0, 1'b0, 1'b0);
    chk("async_reset.r10_count", 64'(bus10.count), 64'd0);
    @(negedge clock);
    reset = 1'b1;
    drive16(vecs[0]);
    chk16("post_reset", 40'h0, 4'd0, 1'b0, 1'b0, 1'b0);
    push16(4'h4);
    chk16("post_reset_push", 40'h4, 4'd1, 1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
